// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the 6-source interrupt controller.
package int_ctrl_pkg;

  localparam int NUM_SRC = 6;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  localparam logic [1:0] ADDR_MASK = 2'd0;
  localparam logic [1:0] ADDR_MODE = 2'd1;
  localparam logic [1:0] ADDR_PEND = 2'd2;
  localparam logic [1:0] ADDR_STAT = 2'd3;

  function automatic logic [NUM_SRC-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot = 6'b000001 << idx;
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: returns the lowest set index of the request vector.
module int_prio_enc
  import int_ctrl_pkg::*;
(
  input  logic [NUM_SRC-1:0] req_i,
  output logic [ID_W-1:0]    idx_o,
  output logic               valid_o
);

  // Bit 0 wins; valid is low only when no bit is set.
  always_comb begin
    idx_o   = 3'd0;
    valid_o = 1'b1;
    casez (req_i)
      6'b?????1: idx_o = 3'd0;
      6'b????10: idx_o = 3'd1;
      6'b???100: idx_o = 3'd2;
      6'b??1000: idx_o = 3'd3;
      6'b?10000: idx_o = 3'd4;
      6'b100000: idx_o = 3'd5;
      default: begin
        idx_o   = 3'd0;
        valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: mask/mode/pending registers, edge detect and a
// three-state request/service handshake towards CP0.
module int_ctrl
  import int_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] IrqIn,
  input  logic               We,
  input  logic [1:0]         Addr,
  input  logic [31:0]        DIn,
  output logic [31:0]        DOut,
  output logic [NUM_SRC-1:0] HWInt,
  input  logic               IntAck,
  output logic               Busy
);

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   mask_q, mask_d;
  logic [NUM_SRC-1:0]   mode_q, mode_d;
  logic [NUM_SRC-1:0]   pend_q, pend_d;
  logic [NUM_SRC-1:0]   prev_q;
  logic [ID_W-1:0]      id_q, id_d;

  logic [NUM_SRC-1:0]   masked_s, rise_s, clr_s, id_oh_s;
  logic [ID_W-1:0]      enc_idx_s;
  logic                 enc_valid_s;
  logic                 wr_mask_s, wr_mode_s, wr_pend_s, eoi_s;
  logic                 unused_din_s;

  assign wr_mask_s    = We && (Addr == ADDR_MASK);
  assign wr_mode_s    = We && (Addr == ADDR_MODE);
  assign wr_pend_s    = We && (Addr == ADDR_PEND);
  assign eoi_s        = We && (Addr == ADDR_STAT);
  assign unused_din_s = ^DIn[31:NUM_SRC];

  assign masked_s = pend_q & mask_q;
  assign rise_s   = IrqIn & ~prev_q;
  assign id_oh_s  = onehot(id_q);

  int_prio_enc u_prio_enc (
    .req_i   (masked_s),
    .idx_o   (enc_idx_s),
    .valid_o (enc_valid_s)
  );

  // Register file next state; a rising edge outranks any clear of the same bit.
  always_comb begin
    mask_d = mask_q;
    mode_d = mode_q;
    clr_s  = '0;
    if (wr_mask_s) begin
      mask_d = DIn[NUM_SRC-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_mode_s) begin
      mode_d = DIn[NUM_SRC-1:0];
    end else begin
      mode_d = mode_q;
    end
    if (wr_pend_s) begin
      clr_s = DIn[NUM_SRC-1:0];
    end else if (eoi_s && (state_q == ST_SERVICE)) begin
      clr_s = id_oh_s;
    end else begin
      clr_s = '0;
    end
    pend_d = (mode_q & (rise_s | (pend_q & ~clr_s))) | (~mode_q & IrqIn);
  end

  // Handshake FSM; id is captured only on entry to REQ.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid_s) begin
          state_d = ST_REQ;
          id_d    = enc_idx_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (IntAck) begin
          state_d = ST_SERVICE;
        end else if ((masked_s & id_oh_s) == 6'd0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_SERVICE: begin
        if (eoi_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SERVICE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      mode_q  <= '0;
      pend_q  <= '0;
      prev_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      pend_q  <= pend_d;
      prev_q  <= IrqIn;
      id_q    <= id_d;
    end
  end

  assign HWInt = (state_q == ST_REQ) ? id_oh_s : 6'd0;
  assign Busy  = (state_q != ST_IDLE);

  // Register read mux.
  always_comb begin
    DOut = 32'd0;
    case (Addr)
      ADDR_MASK: DOut = {26'd0, mask_q};
      ADDR_MODE: DOut = {26'd0, mode_q};
      ADDR_PEND: DOut = {26'd0, pend_q};
      ADDR_STAT: DOut = {27'd0, state_q, id_q};
      default:   DOut = 32'd0;
    endcase
  end

endmodule
